// File: rtl/prio_encoder_drain.sv
// prio_encoder_drain: latches a request vector and emits every set index in priority order, one per handshake
module prio_encoder_drain #(
  parameter int N = 8,
  parameter bit MSB_PRIO = 1'b1,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ei,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [N-1:0]  d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] idx,
  output logic          gs,
  output logic          last,
  output logic [N-1:0]  pending
);
  typedef enum logic [1:0] {IDLE, BUSY, ZERO} state_t;
  state_t state;
  logic [IW-1:0] sel;
  logic [IW-1:0] k;
  logic single;
  always_comb begin
    sel = '0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'(MSB_PRIO ? i : N - 1 - i);
      sel = pending[k] ? k : sel;
    end
  end
  assign single = (pending & (pending - 1'b1)) == '0;
  assign d_ready = (state == IDLE) && ei && !rst;
  assign out_valid = state != IDLE;
  assign gs = state == BUSY;
  assign idx = (state == BUSY) ? sel : '0;
  assign last = (state == ZERO) || ((state == BUSY) && single);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
    end else if (state == IDLE) begin
      if (d_valid && d_ready) begin
        pending <= d;
        state <= (|d) ? BUSY : ZERO;
      end
    end else if (state == BUSY) begin
      if (out_ready) begin
        pending[sel] <= 1'b0;
        state <= single ? IDLE : BUSY;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_prio_encoder_drain.sv
// tb_prio_encoder_drain: directed self-checking bench for prio_encoder_drain (N=8 MSB-first, N=16 LSB-first)
module tb_prio_encoder_drain;
  logic clk = 1'b0;
  logic rst, ei;
  logic dv8, dr8, ov8, or8, gs8, last8;
  logic [7:0] d8, pend8;
  logic [2:0] idx8;
  logic dv16, dr16, ov16, or16, gs16, last16;
  logic [15:0] d16, pend16;
  logic [3:0] idx16;
  int checks = 0;
  int failures = 0;
  int beats8 = 0;
  int b0;
  always #5 clk = ~clk;
  prio_encoder_drain #(.N(8), .MSB_PRIO(1'b1)) u8 (
    .clk(clk), .rst(rst), .ei(ei), .d_valid(dv8), .d_ready(dr8), .d(d8),
    .out_valid(ov8), .out_ready(or8), .idx(idx8), .gs(gs8), .last(last8), .pending(pend8)
  );
  prio_encoder_drain #(.N(16), .MSB_PRIO(1'b0)) u16 (
    .clk(clk), .rst(rst), .ei(ei), .d_valid(dv16), .d_ready(dr16), .d(d16),
    .out_valid(ov16), .out_ready(or16), .idx(idx16), .gs(gs16), .last(last16), .pending(pend16)
  );
  always @(posedge clk) if (!rst && ov8 && or8) beats8++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat8(input string tag, input logic [2:0] ei_idx, input logic el, input logic [7:0] ep);
    chk({tag, "_valid"}, ov8, 1'b1);
    chk({tag, "_gs"}, gs8, 1'b1);
    chk({tag, "_idx"}, idx8, ei_idx);
    chk({tag, "_last"}, last8, el);
    chk({tag, "_pend"}, pend8, ep);
    chk({tag, "_dready"}, dr8, 1'b0);
  endtask
  initial begin
    rst = 1; ei = 0; dv8 = 0; d8 = 0; or8 = 0; dv16 = 0; d16 = 0; or16 = 0;
    tick(); tick();
    chk("rst_valid", ov8, 1'b0);
    chk("rst_pend", pend8, 8'h00);
    chk("rst_idx", idx8, 3'd0);
    chk("rst_gs", gs8, 1'b0);
    chk("rst_last", last8, 1'b0);
    ei = 1; #1;
    chk("rst_dready", dr8, 1'b0);
    rst = 0; #1;
    chk("idle_dready", dr8, 1'b1);
    d8 = 8'hA6; dv8 = 1; or8 = 1;
    tick(); dv8 = 0;
    beat8("t1b1", 3'd7, 1'b0, 8'hA6); tick();
    beat8("t1b2", 3'd5, 1'b0, 8'h26); tick();
    beat8("t1b3", 3'd2, 1'b0, 8'h06); tick();
    beat8("t1b4", 3'd1, 1'b1, 8'h02); tick();
    chk("t1_done_valid", ov8, 1'b0);
    chk("t1_done_pend", pend8, 8'h00);
    chk("t1_done_dready", dr8, 1'b1);
    b0 = beats8;
    dv8 = 1; tick(); dv8 = 0;
    beat8("t2b1", 3'd7, 1'b0, 8'hA6); tick();
    or8 = 0;
    for (int i = 0; i < 3; i++) begin
      beat8("t2hold", 3'd5, 1'b0, 8'h26); tick();
    end
    or8 = 1;
    beat8("t2b2", 3'd5, 1'b0, 8'h26); tick();
    beat8("t2b3", 3'd2, 1'b0, 8'h06); tick();
    beat8("t2b4", 3'd1, 1'b1, 8'h02); tick();
    chk("t2_beats", beats8 - b0, 4);
    chk("t2_done_dready", dr8, 1'b1);
    d8 = 8'h00; dv8 = 1; tick(); dv8 = 0;
    chk("t3_valid", ov8, 1'b1);
    chk("t3_gs", gs8, 1'b0);
    chk("t3_idx", idx8, 3'd0);
    chk("t3_last", last8, 1'b1);
    chk("t3_dready", dr8, 1'b0);
    tick();
    chk("t3_done_valid", ov8, 1'b0);
    chk("t3_done_dready", dr8, 1'b1);
    ei = 0; d8 = 8'h10; dv8 = 1; or8 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_gated_dready", dr8, 1'b0);
      tick();
      chk("t4_gated_valid", ov8, 1'b0);
    end
    ei = 1; #1;
    chk("t4_en_dready", dr8, 1'b1);
    tick();
    beat8("t4b1", 3'd4, 1'b1, 8'h10);
    d8 = 8'hFF; tick();
    beat8("t4ign", 3'd4, 1'b1, 8'h10);
    dv8 = 0; or8 = 1; tick();
    chk("t4_done_valid", ov8, 1'b0);
    chk("t4_done_pend", pend8, 8'h00);
    b0 = beats8;
    d8 = 8'hC1; dv8 = 1; tick(); dv8 = 0;
    beat8("t5b1", 3'd7, 1'b0, 8'hC1); tick();
    beat8("t5b2", 3'd6, 1'b0, 8'h41);
    rst = 1; or8 = 0; tick(); rst = 0; or8 = 1;
    chk("t5_rst_valid", ov8, 1'b0);
    chk("t5_rst_pend", pend8, 8'h00);
    chk("t5_rst_idx", idx8, 3'd0);
    tick(); tick();
    chk("t5_after_valid", ov8, 1'b0);
    chk("t5_beats", beats8 - b0, 1);
    d16 = 16'h8001; dv16 = 1; or16 = 1; tick(); dv16 = 0;
    chk("t6b1_valid", ov16, 1'b1);
    chk("t6b1_idx", idx16, 4'd0);
    chk("t6b1_last", last16, 1'b0);
    chk("t6b1_pend", pend16, 16'h8001);
    tick();
    chk("t6b2_idx", idx16, 4'd15);
    chk("t6b2_last", last16, 1'b1);
    chk("t6b2_gs", gs16, 1'b1);
    chk("t6b2_pend", pend16, 16'h8000);
    tick();
    chk("t6_done_valid", ov16, 1'b0);
    chk("t6_done_dready", dr16, 1'b1);
    d16 = 16'h0100; dv16 = 1; tick(); dv16 = 0;
    chk("t6s_idx", idx16, 4'd8);
    chk("t6s_last", last16, 1'b1);
    chk("t6s_gs", gs16, 1'b1);
    tick();
    chk("t6s_done_valid", ov16, 1'b0);
    chk("t6s_done_pend", pend16, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
